alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_seq_if.sv | 32 +++
 rtl/mul8_shift.sv | 47 ++++
 rtl/alu_seq.sv | 97 +++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute/write-back sequencer: widths, op codes,
// FSM states and the single-cycle result/flag evaluation.
package alu_pkg;

  localparam int W         = 8;
  localparam int RW        = 3;
  localparam int MUL_STEPS = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_MOV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    WB    = 2'b11
  } state_e;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cf;
  } alu_res_t;

  // MUL takes its result from the iterative multiplier's product.
  function automatic alu_res_t alu_eval(input op_e op, input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [2*W-1:0] prod);
    alu_res_t r;
    logic [W:0] s;
    r = '0;
    s = '0;
    case (op)
      OP_ADD: begin
        s     = {1'b0, a} + {1'b0, b};
        r.res = s[W-1:0];
        r.cf  = s[W];
      end
      OP_SUB: begin
        s     = {1'b0, a} - {1'b0, b};
        r.res = s[W-1:0];
        r.cf  = s[W];
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_SHL: begin
        r.res = {a[W-2:0], 1'b0};
        r.cf  = a[W-1];
      end
      OP_MUL: begin
        r.res = prod[W-1:0];
        r.cf  = |prod[2*W-1:W];
      end
      OP_MOV: r.res = a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Instruction request plus register-file read/write bus of the sequencer.
interface alu_seq_if;
  import alu_pkg::*;

  logic          start;
  logic [2:0]    op;
  logic [RW-1:0] ra;
  logic [RW-1:0] rb;
  logic [RW-1:0] rd;
  logic [RW-1:0] asel;
  logic [RW-1:0] bsel;
  logic [W-1:0]  aout;
  logic [W-1:0]  bout;
  logic          cload;
  logic [RW-1:0] csel;
  logic [W-1:0]  cin;
  logic          busy;
  logic          done;
  logic          zf;
  logic          cf;

  modport slave (
    input  start, op, ra, rb, rd, aout, bout,
    output asel, bsel, cload, csel, cin, busy, done, zf, cf
  );

  modport master (
    output start, op, ra, rb, rd, aout, bout,
    input  asel, bsel, cload, csel, cin, busy, done, zf, cf
  );

endinterface

// File: rtl/mul8_shift.sv
// Iterative shift-add multiplier: one partial product per cycle while go is
// held, fin on the eighth cycle with prod carrying the complete product.
module mul8_shift
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             go,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   prod,
  output logic             fin
);

  localparam int CW = $clog2(MUL_STEPS);

  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] acc_next;
  logic [CW-1:0]  cnt_reg;
  logic [2*W-1:0] pp [W];

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? ({{W{1'b0}}, a} << gi) : '0;
    end
  endgenerate

  assign acc_next = acc_reg + pp[cnt_reg];
  // prod includes the current step so the caller can capture it on fin.
  assign prod     = acc_next;
  assign fin      = go && (cnt_reg == CW'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (go) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + CW'(1);
    end else begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute/write-back sequencer: IDLE -> FETCH -> EXEC (1 or 8 cycles) -> WB,
// reading operands from and writing the result back into the register file.
module alu_seq
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      clrn,
  alu_seq_if.slave  bus
);

  state_e         state_reg;
  state_e         state_next;
  op_e            op_reg;
  logic [RW-1:0]  ra_reg;
  logic [RW-1:0]  rb_reg;
  logic [RW-1:0]  rd_reg;
  logic [W-1:0]   opa_reg;
  logic [W-1:0]   opb_reg;
  logic [W-1:0]   res_reg;
  logic           zf_reg;
  logic           cf_reg;

  logic           accept;
  logic           mul_go;
  logic           mul_fin;
  logic [2*W-1:0] mul_prod;
  alu_res_t       alu_out;

  assign accept  = (state_reg == IDLE) && bus.start;
  assign mul_go  = (state_reg == EXEC) && (op_reg == OP_MUL);
  assign alu_out = alu_eval(op_reg, opa_reg, opb_reg, mul_prod);

  mul8_shift u_mul (
    .clk  (clk),
    .clrn (clrn),
    .go   (mul_go),
    .a    (opa_reg),
    .b    (opb_reg),
    .prod (mul_prod),
    .fin  (mul_fin)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    if ((op_reg != OP_MUL) || mul_fin) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg <= IDLE;
      op_reg    <= OP_ADD;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rd_reg    <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      zf_reg    <= 1'b0;
      cf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= op_e'(bus.op);
        ra_reg <= bus.ra;
        rb_reg <= bus.rb;
        rd_reg <= bus.rd;
      end
      if (state_reg == FETCH) begin
        opa_reg <= bus.aout;
        opb_reg <= bus.bout;
      end
      // Result and flags land on entry to WB so they are valid alongside cload.
      if ((state_reg == EXEC) && (state_next == WB)) begin
        res_reg <= alu_out.res;
        zf_reg  <= (alu_out.res == '0);
        cf_reg  <= alu_out.cf;
      end
    end
  end

  assign bus.asel  = ra_reg;
  assign bus.bsel  = rb_reg;
  assign bus.cload = (state_reg == WB);
  assign bus.done  = (state_reg == WB);
  assign bus.csel  = rd_reg;
  assign bus.cin   = res_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.zf    = zf_reg;
  assign bus.cf    = cf_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural 8x8 register file closing the loop.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic clrn;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] rf  [8];
  logic [7:0] mrf [8];
  logic       pl_en;
  logic [2:0] pl_sel;
  logic [7:0] pl_data;

  alu_seq_if bus();

  alu_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.aout = rf[bus.asel];
  assign bus.bout = rf[bus.bsel];

  always @(posedge clk) begin
    if (pl_en) rf[pl_sel] <= pl_data;
    else if (bus.cload) rf[bus.csel] <= bus.cin;
  end

  // Reference: result byte and carry from plain integer arithmetic.
  function automatic logic [8:0] ref_op(input int o, input int a, input int b);
    int   r;
    logic c;
    r = 0;
    c = 1'b0;
    case (o)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = (a >= 128); end
      6: begin r = a * b; c = (r > 255); end
      default: r = a;
    endcase
    return {c, 8'(r & 255)};
  endfunction

  task automatic preload(input logic [2:0] s, input logic [7:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = s; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
    mrf[s] = v;
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, output int lat, output logic [2:0] sel,
                       output logic [7:0] data, output logic dn, output logic z,
                       output logic c, output int nloads);
    lat = -1; sel = '0; data = '0; dn = 1'b0; z = 1'b0; c = 1'b0; nloads = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.ra = a; bus.rb = b; bus.rd = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (bus.cload) begin
        nloads++;
        if (lat < 0) begin
          lat = cyc; sel = bus.csel; data = bus.cin; dn = bus.done;
        end
      end
      if (lat >= 0 && cyc == lat + 1) begin
        z = bus.zf; c = bus.cf;
        break;
      end
    end
    $display("txn op=%0d ra=%0d rb=%0d rd=%0d cin=%02h zf=%0b cf=%0b lat=%0d",
             o, a, b, d, data, z, c, lat);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    #12;
    total++;
    if ({bus.busy, bus.done, bus.cload, bus.zf, bus.cf} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000",
                      {bus.busy, bus.done, bus.cload, bus.zf, bus.cf});
    end
    total++;
    if ({bus.asel, bus.bsel, bus.csel, bus.cin} !== 17'b0) begin
      bad++; $display("FAIL reset_bus got=%h want=0", {bus.asel, bus.bsel, bus.csel, bus.cin});
    end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_add();
    int lat, n; logic [2:0] sel; logic [7:0] data; logic dn, z, c;
    preload(3'd1, 8'hFF); preload(3'd2, 8'h01);
    issue(3'b000, 3'd1, 3'd2, 3'd3, lat, sel, data, dn, z, c, n);
    total++; if (lat !== 3) begin bad++; $display("FAIL add_lat got=%0d want=3", lat); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL add_done got=%b want=1", dn); end
    total++; if (sel !== 3'd3) begin bad++; $display("FAIL add_csel got=%0d want=3", sel); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL add_cin got=%02h want=00", data); end
    total++; if ({z, c} !== 2'b11) begin bad++; $display("FAIL add_flags got=%b want=11", {z, c}); end
    total++; if (n !== 1) begin bad++; $display("FAIL add_nloads got=%0d want=1", n); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", bus.done); end
    total++; if (rf[3] !== 8'h00) begin bad++; $display("FAIL add_r3 got=%02h want=00", rf[3]); end
  endtask

  task automatic test_sub();
    int lat, n; logic [2:0] sel; logic [7:0] data; logic dn, z, c;
    preload(3'd1, 8'h05); preload(3'd2, 8'h07);
    issue(3'b001, 3'd1, 3'd2, 3'd4, lat, sel, data, dn, z, c, n);
    total++; if (lat !== 3) begin bad++; $display("FAIL sub_lat got=%0d want=3", lat); end
    total++; if (rf[4] !== 8'hFE) begin bad++; $display("FAIL sub_r4 got=%02h want=fe", rf[4]); end
    total++; if ({z, c} !== 2'b01) begin bad++; $display("FAIL sub_flags got=%b want=01", {z, c}); end
  endtask

  task automatic test_mul();
    int lat, n; logic [2:0] sel; logic [7:0] data; logic dn, z, c;
    preload(3'd1, 8'h0D); preload(3'd2, 8'h0B);
    issue(3'b110, 3'd1, 3'd2, 3'd5, lat, sel, data, dn, z, c, n);
    total++; if (lat !== 10) begin bad++; $display("FAIL mul_lat got=%0d want=10", lat); end
    total++; if (rf[5] !== 8'h8F) begin bad++; $display("FAIL mul_r5 got=%02h want=8f", rf[5]); end
    total++; if ({z, c} !== 2'b00) begin bad++; $display("FAIL mul_flags got=%b want=00", {z, c}); end
    preload(3'd1, 8'h10); preload(3'd2, 8'h10);
    issue(3'b110, 3'd1, 3'd2, 3'd6, lat, sel, data, dn, z, c, n);
    total++; if (rf[6] !== 8'h00) begin bad++; $display("FAIL mul2_r6 got=%02h want=00", rf[6]); end
    total++; if ({z, c} !== 2'b11) begin bad++; $display("FAIL mul2_flags got=%b want=11", {z, c}); end
  endtask

  task automatic test_back_to_back();
    int loads, first, second;
    logic busy4, busy5;
    logic [5:0] sels;
    loads = 0; first = -1; second = -1; busy4 = 1'bx; busy5 = 1'bx; sels = 'x;
    preload(3'd1, 8'h21); preload(3'd2, 8'h13);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.ra = 3'd1; bus.rb = 3'd2; bus.rd = 3'd3;
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) sels = {bus.asel, bus.bsel};
      if (cyc == 4) busy4 = bus.busy;
      if (cyc == 5) busy5 = bus.busy;
      if (bus.cload) begin
        loads++;
        if (first < 0) first = cyc; else second = cyc;
      end
      if (cyc == 6) bus.start = 1'b0;
    end
    $display("txn b2b loads=%0d first=%0d second=%0d", loads, first, second);
    total++; if (loads !== 2) begin bad++; $display("FAIL b2b_loads got=%0d want=2", loads); end
    total++; if (first !== 3 || second !== 7) begin
      bad++; $display("FAIL b2b_wb_cycles got=%0d,%0d want=3,7", first, second);
    end
    total++; if ({busy4, busy5} !== 2'b01) begin bad++; $display("FAIL b2b_busy got=%b want=01", {busy4, busy5}); end
    total++; if (sels !== {3'd1, 3'd2}) begin bad++; $display("FAIL b2b_fetch_sel got=%b want=001010", sels); end
    total++; if (rf[3] !== 8'h34) begin bad++; $display("FAIL b2b_r3 got=%02h want=34", rf[3]); end
  endtask

  task automatic test_reset_abort();
    int lat, n, loads; logic [2:0] sel; logic [7:0] data; logic dn, z, c;
    preload(3'd5, 8'hAA); preload(3'd1, 8'h03); preload(3'd2, 8'h04);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.ra = 3'd1; bus.rb = 3'd2; bus.rd = 3'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
    clrn = 1'b0;
    #1;
    total++; if ({bus.busy, bus.cload, bus.done} !== 3'b000) begin
      bad++; $display("FAIL abort_outputs got=%b want=000", {bus.busy, bus.cload, bus.done});
    end
    @(negedge clk);
    clrn = 1'b1;
    loads = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.cload) loads++;
    end
    $display("txn abort mul rd=5 loads_after=%0d r5=%02h", loads, rf[5]);
    total++; if (loads !== 0) begin bad++; $display("FAIL abort_loads got=%0d want=0", loads); end
    total++; if (rf[5] !== 8'hAA) begin bad++; $display("FAIL abort_r5 got=%02h want=aa", rf[5]); end
    issue(3'b000, 3'd1, 3'd2, 3'd6, lat, sel, data, dn, z, c, n);
    total++; if (lat !== 3 || rf[6] !== 8'h07) begin
      bad++; $display("FAIL abort_next_add got=lat%0d r6=%02h want=lat3 r6=07", lat, rf[6]);
    end
    issue(3'b110, 3'd1, 3'd2, 3'd7, lat, sel, data, dn, z, c, n);
    total++; if (lat !== 10 || rf[7] !== 8'h0C) begin
      bad++; $display("FAIL abort_next_mul got=lat%0d r7=%02h want=lat10 r7=0c", lat, rf[7]);
    end
  endtask

  task automatic test_dependency();
    int lat, n; logic [2:0] sel; logic [7:0] data; logic dn, z, c;
    preload(3'd1, 8'h3C); preload(3'd2, 8'h15); preload(3'd7, 8'hEE);
    issue(3'b000, 3'd1, 3'd2, 3'd3, lat, sel, data, dn, z, c, n);
    issue(3'b111, 3'd3, 3'd0, 3'd7, lat, sel, data, dn, z, c, n);
    total++; if (rf[7] !== 8'h51) begin bad++; $display("FAIL dep_r7 got=%02h want=51", rf[7]); end
    total++; if ({z, c} !== 2'b00) begin bad++; $display("FAIL dep_flags got=%b want=00", {z, c}); end
  endtask

  task automatic test_random();
    int lat, n; logic [2:0] sel; logic [7:0] data; logic dn, z, c;
    logic [2:0] o, a, b, d;
    logic [8:0] exp;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom_range(0, 255)));
    for (int t = 0; t < 32; t++) begin
      o = 3'($urandom_range(0, 7));
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      exp = ref_op(int'(o), int'(mrf[a]), int'(mrf[b]));
      issue(o, a, b, d, lat, sel, data, dn, z, c, n);
      mrf[d] = exp[7:0];
      total++; if (lat !== ((o == 3'b110) ? 10 : 3)) begin
        bad++; $display("FAIL rnd_lat t=%0d op=%0d got=%0d", t, o, lat);
      end
      total++; if (data !== exp[7:0] || rf[d] !== exp[7:0]) begin
        bad++; $display("FAIL rnd_result t=%0d op=%0d got=%02h/%02h want=%02h", t, o, data, rf[d], exp[7:0]);
      end
      total++; if ({z, c} !== {(exp[7:0] == 8'h00), exp[8]}) begin
        bad++; $display("FAIL rnd_flags t=%0d op=%0d got=%b want=%b", t, o, {z, c},
                        {(exp[7:0] == 8'h00), exp[8]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.ra = '0; bus.rb = '0; bus.rd = '0;
    pl_en = 1'b0; pl_sel = '0; pl_data = '0;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'h00;
      mrf[i] = 8'h00;
    end
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    test_dependency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
